pipe_stage_reg: RTL

Generic valid/ready pipeline stage register that replaces the fixed, always-advancing inter-stage registers between IF/ID/EX/MEM/WB. The payload is one parametrised bus, so each stage packs its fields (pc, immediate, operands, control) into it. The block adds backpressure (stall), flush (bubble insertion on branch/exception) and an optional skid buffer that keeps `in_ready_o` registered. One instance sits on each stage boundary of the rv32 core.

---
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic valid/ready register stage placed on every boundary of the rv32
// pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage packs its fields into
// one DATA_W-bit payload bus. The stage supports backpressure, flush (bubble
// insertion on branch/exception) and an optional skid register.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : two entries (main + skid), in_ready_o comes straight from a
//               flop, occupancy_o ranges 0..2.
//   undefined : single entry, in_ready_o = ~out_valid_o | out_ready_i
//               (combinational from out_ready_i), occupancy_o ranges 0..1.
//
// Parameters
//   DATA_W   payload width in bits
//   RST_VAL  value loaded into every payload register on reset
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   flush_i      in   drop every beat held in the stage at the next edge
//   in_valid_i   in   upstream beat valid
//   in_ready_o   out  stage can accept a beat this cycle
//   in_data_i    in   upstream payload
//   out_valid_o  out  downstream beat valid
//   out_ready_i  in   downstream accepts
//   out_data_o   out  downstream payload (main register)
//   occupancy_o  out  number of beats held, registered
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned          DATA_W  = 128,
  parameter logic [DATA_W-1:0]    RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  // Stage states named by how many beats are held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stageState_t;

  stageState_t       r_state;
  logic              r_outValid;
  logic [1:0]        r_occupancy;
  logic [DATA_W-1:0] r_mainData;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skidData;
  logic              r_inReady;
`endif

  logic w_inReady;
  logic w_accept;
  logic w_deliver;

  // Handshake qualifiers. In skid mode the ready comes from a flop that is
  // high exactly when the skid entry is free, so upstream timing never sees
  // out_ready_i. Without the skid entry the stage can only take a new beat
  // when the main register is empty or is being emptied this same cycle.
`ifdef PIPE_STAGE_SKID_EN
  assign w_inReady = r_inReady;
`else
  assign w_inReady = ~r_outValid | out_ready_i;
`endif

  assign w_accept  = in_valid_i & w_inReady;
  assign w_deliver = r_outValid & out_ready_i;

  // Single state machine owning every register of the stage. Reset beats
  // flush, and flush beats any transfer: on flush only the valid/state bits
  // clear while the payload registers keep whatever they held, so a beat
  // accepted in the flush cycle is silently dropped. Payload registers only
  // load on a real beat move, which keeps out_data_o stable during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_outValid  <= 1'b0;
      r_occupancy <= 2'd0;
      r_mainData  <= RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
      r_skidData  <= RST_VAL;
      r_inReady   <= 1'b1;
`endif
    end else if (flush_i) begin
      r_state     <= ST_EMPTY;
      r_outValid  <= 1'b0;
      r_occupancy <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      r_inReady   <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_mainData  <= in_data_i;
            r_state     <= ST_ONE;
            r_outValid  <= 1'b1;
            r_occupancy <= 2'd1;
          end
        end

        ST_ONE: begin
          if (w_accept && w_deliver) begin
            r_mainData <= in_data_i;
          end else if (w_deliver) begin
            r_state     <= ST_EMPTY;
            r_outValid  <= 1'b0;
            r_occupancy <= 2'd0;
          end else if (w_accept) begin
`ifdef PIPE_STAGE_SKID_EN
            r_skidData  <= in_data_i;
            r_state     <= ST_FULL;
            r_occupancy <= 2'd2;
            r_inReady   <= 1'b0;
`else
            r_state     <= ST_ONE;
`endif
          end
        end

        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_deliver) begin
            r_mainData  <= r_skidData;
            r_state     <= ST_ONE;
            r_occupancy <= 2'd1;
            r_inReady   <= 1'b1;
          end
`else
          r_state     <= ST_EMPTY;
          r_outValid  <= 1'b0;
          r_occupancy <= 2'd0;
`endif
        end

        default: begin
          r_state     <= ST_EMPTY;
          r_outValid  <= 1'b0;
          r_occupancy <= 2'd0;
        end
      endcase
    end
  end

  // Outputs are straight register reads; nothing bypasses from in to out.
  assign in_ready_o  = w_inReady;
  assign out_valid_o = r_outValid;
  assign out_data_o  = r_mainData;
  assign occupancy_o = r_occupancy;

endmodule
